// File: rtl/operand_entry.sv
// Calculator operand entry: turns decoded keys into two signed decimal operands plus an operator.
// Requests a computation on '=' and feeds the display stage with the operand being typed or the result.
module operand_entry #(
  parameter int MAX_DIGITS = 5,
  parameter int WIDTH      = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             KeyRdy,
  output logic             KeyRd,
  input  logic [3:0]       keypad_input,
  input  logic [2:0]       operator_input,
  input  logic             equal_input,
  output logic             calc_req,
  input  logic             calc_ack,
  input  logic [WIDTH-1:0] calc_result,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [2:0]       op_code,
  output logic [WIDTH-1:0] display_value,
  output logic             entry_err
);
  localparam int            CW      = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);
  localparam logic [19:0]   MAG_MAX = 20'((1 << (WIDTH - 1)) - 1);
  localparam logic [2:0]    OP_SUB  = 3'b010;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, RESULT} state_t;

  state_t           state;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_a, neg_b;
  logic [CW-1:0]    cnt_a, cnt_b;

  logic             accept, k_eq, k_op, k_dig, op_valid;
  logic [19:0]      nxt_mag_a, nxt_mag_b;
  logic [WIDTH-1:0] new_a, new_b;
  logic             dig_ok_a, dig_ok_b;

  function automatic logic [WIDTH-1:0] sval(input logic neg, input logic [WIDTH-1:0] m);
    return neg ? -m : m;
  endfunction

  // Key classes in priority order: '=' beats any operator code, which beats a digit.
  assign accept   = KeyRdy && !KeyRd && (state != CALC);
  assign k_eq     = equal_input;
  assign k_op     = !equal_input && (operator_input != 3'd0);
  assign op_valid = k_op && (operator_input <= 3'd4);
  assign k_dig    = !equal_input && (operator_input == 3'd0) && (keypad_input <= 4'd9);

  assign nxt_mag_a = 20'(mag_a) * 20'd10 + 20'(keypad_input);
  assign nxt_mag_b = 20'(mag_b) * 20'd10 + 20'(keypad_input);
  assign new_a     = nxt_mag_a[WIDTH-1:0];
  assign new_b     = nxt_mag_b[WIDTH-1:0];
  assign dig_ok_a  = (cnt_a != CNT_MAX) && (nxt_mag_a <= MAG_MAX);
  assign dig_ok_b  = (cnt_b != CNT_MAX) && (nxt_mag_b <= MAG_MAX);

  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= ENTER_A;
      KeyRd     <= 1'b0;
      calc_req  <= 1'b0;
      operand_a <= '0;
      operand_b <= '0;
      op_code   <= '0;
      entry_err <= 1'b0;
      mag_a     <= '0;
      mag_b     <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      cnt_a     <= '0;
      cnt_b     <= '0;
    end else begin
      KeyRd <= accept;
      if (state == CALC && calc_ack) begin
        operand_a <= calc_result;
        calc_req  <= 1'b0;
        state     <= RESULT;
      end
      if (accept) begin
        case (state)
          ENTER_A: begin
            if (op_valid) begin
              if (operator_input == OP_SUB && cnt_a == '0 && !neg_a) begin
                neg_a     <= 1'b1;
                entry_err <= 1'b0;
              end else if (cnt_a != '0) begin
                op_code   <= operator_input;
                mag_b     <= '0;
                neg_b     <= 1'b0;
                cnt_b     <= '0;
                operand_b <= '0;
                state     <= ENTER_B;
              end
            end else if (k_dig) begin
              if (dig_ok_a) begin
                mag_a     <= new_a;
                operand_a <= sval(neg_a, new_a);
                cnt_a     <= cnt_a + CW'(1);
                if (cnt_a == '0) entry_err <= 1'b0;
              end else begin
                entry_err <= 1'b1;
              end
            end
          end
          ENTER_B: begin
            if (op_valid) begin
              // With no B digits yet, '-' is a sign unless the pending operator is already subtract.
              if (cnt_b == '0) begin
                if (operator_input == OP_SUB && op_code != OP_SUB && !neg_b) begin
                  neg_b     <= 1'b1;
                  entry_err <= 1'b0;
                end else begin
                  op_code <= operator_input;
                end
              end
            end else if (k_dig) begin
              if (dig_ok_b) begin
                mag_b     <= new_b;
                operand_b <= sval(neg_b, new_b);
                cnt_b     <= cnt_b + CW'(1);
                if (cnt_b == '0) entry_err <= 1'b0;
              end else begin
                entry_err <= 1'b1;
              end
            end else if (k_eq && cnt_b != '0) begin
              calc_req <= 1'b1;
              state    <= CALC;
            end
          end
          RESULT: begin
            if (op_valid) begin
              op_code   <= operator_input;
              mag_b     <= '0;
              neg_b     <= 1'b0;
              cnt_b     <= '0;
              operand_b <= '0;
              state     <= ENTER_B;
            end else if (k_dig) begin
              mag_a     <= WIDTH'(keypad_input);
              operand_a <= WIDTH'(keypad_input);
              neg_a     <= 1'b0;
              cnt_a     <= CW'(1);
              entry_err <= 1'b0;
              state     <= ENTER_A;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    display_value = operand_a;
    if (state == ENTER_B && (cnt_b != '0 || neg_b)) display_value = operand_b;
  end

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: key/ack/reset vector table checked through a scoreboard, plus stall and reset-in-CALC sequences.
module tb_operand_entry;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             RST, KeyRdy, KeyRd, equal_input, calc_req, calc_ack, entry_err;
  logic [3:0]       keypad_input;
  logic [2:0]       operator_input, op_code;
  logic [WIDTH-1:0] calc_result, operand_a, operand_b, display_value;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  operand_entry #(.MAX_DIGITS(5), .WIDTH(WIDTH)) dut (
    .clk(clk), .RST(RST), .KeyRdy(KeyRdy), .KeyRd(KeyRd),
    .keypad_input(keypad_input), .operator_input(operator_input), .equal_input(equal_input),
    .calc_req(calc_req), .calc_ack(calc_ack), .calc_result(calc_result),
    .operand_a(operand_a), .operand_b(operand_b), .op_code(op_code),
    .display_value(display_value), .entry_err(entry_err)
  );

  typedef enum int {K_DIG, K_OP, K_EQ, K_ACK, K_RST} kind_t;
  typedef struct {
    kind_t       kind;
    logic [15:0] val;
    logic [15:0] a, b;
    logic [2:0]  op;
    logic [15:0] disp;
    logic        err, req;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input kind_t k, input logic [15:0] v, input logic [15:0] a, input logic [15:0] b,
                     input logic [2:0] op, input logic [15:0] d, input logic err, input logic req);
    vec_t t;
    t.kind = k; t.val = v; t.a = a; t.b = b; t.op = op; t.disp = d; t.err = err; t.req = req;
    tbl.push_back(t);
  endtask

  task automatic cmp(input int i, input vec_t e);
    chk($sformatf("operand_a[%0d]", i), operand_a, e.a);
    chk($sformatf("operand_b[%0d]", i), operand_b, e.b);
    chk($sformatf("op_code[%0d]", i), op_code, e.op);
    chk($sformatf("display[%0d]", i), display_value, e.disp);
    chk($sformatf("entry_err[%0d]", i), entry_err, e.err);
    chk($sformatf("calc_req[%0d]", i), calc_req, e.req);
  endtask

  task automatic drive_key(input kind_t k, input logic [15:0] v);
    keypad_input   = (k == K_DIG) ? v[3:0] : 4'd0;
    operator_input = (k == K_OP) ? v[2:0] : 3'd0;
    equal_input    = (k == K_EQ);
    KeyRdy         = 1'b1;
  endtask

  task automatic release_key();
    KeyRdy = 1'b0; keypad_input = 4'd0; operator_input = 3'd0; equal_input = 1'b0;
  endtask

  task automatic press(input kind_t k, input logic [15:0] v);
    int n;
    drive_key(k, v);
    n = 0;
    do begin @(negedge clk); n++; end while (!KeyRd && n < 20);
    chk("press_ack", KeyRd, 1'b1);
    release_key();
    @(negedge clk);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
  endtask

  initial begin
    int   n, pulses;
    vec_t v, e;
    RST = 1'b1; calc_ack = 1'b0; calc_result = '0;
    release_key();
    repeat (2) @(negedge clk);
    RST = 1'b0;
    chk("rst_keyrd", KeyRd, 1'b0);
    chk("rst_req", calc_req, 1'b0);
    chk("rst_a", operand_a, 16'd0);
    chk("rst_b", operand_b, 16'd0);
    chk("rst_op", op_code, 3'd0);
    chk("rst_disp", display_value, 16'd0);
    chk("rst_err", entry_err, 1'b0);

    //     kind   val        a          b          op  disp       err req
    add(K_DIG, 16'd1,     16'd1,     16'd0,     3'd0, 16'd1,     0, 0);
    add(K_DIG, 16'd2,     16'd12,    16'd0,     3'd0, 16'd12,    0, 0);
    add(K_DIG, 16'd3,     16'd123,   16'd0,     3'd0, 16'd123,   0, 0);
    add(K_OP,  16'd1,     16'd123,   16'd0,     3'd1, 16'd123,   0, 0);
    add(K_DIG, 16'd4,     16'd123,   16'd4,     3'd1, 16'd4,     0, 0);
    add(K_DIG, 16'd5,     16'd123,   16'd45,    3'd1, 16'd45,    0, 0);
    add(K_EQ,  16'd0,     16'd123,   16'd45,    3'd1, 16'd123,   0, 1);
    add(K_ACK, 16'd168,   16'd168,   16'd45,    3'd1, 16'd168,   0, 0);
    add(K_OP,  16'd2,     16'd168,   16'd0,     3'd2, 16'd168,   0, 0);
    add(K_DIG, 16'd8,     16'd168,   16'd8,     3'd2, 16'd8,     0, 0);
    add(K_EQ,  16'd0,     16'd168,   16'd8,     3'd2, 16'd168,   0, 1);
    add(K_ACK, 16'd160,   16'd160,   16'd8,     3'd2, 16'd160,   0, 0);
    add(K_DIG, 16'd2,     16'd2,     16'd8,     3'd2, 16'd2,     0, 0);
    add(K_DIG, 16'd3,     16'd23,    16'd8,     3'd2, 16'd23,    0, 0);
    // Signed operands
    add(K_RST, 16'd0,     16'd0,     16'd0,     3'd0, 16'd0,     0, 0);
    add(K_OP,  16'd1,     16'd0,     16'd0,     3'd0, 16'd0,     0, 0);
    add(K_OP,  16'd2,     16'd0,     16'd0,     3'd0, 16'd0,     0, 0);
    add(K_OP,  16'd2,     16'd0,     16'd0,     3'd0, 16'd0,     0, 0);
    add(K_DIG, 16'd7,     16'hFFF9,  16'd0,     3'd0, 16'hFFF9,  0, 0);
    add(K_OP,  16'd3,     16'hFFF9,  16'd0,     3'd3, 16'hFFF9,  0, 0);
    add(K_OP,  16'd2,     16'hFFF9,  16'd0,     3'd3, 16'd0,     0, 0);
    add(K_DIG, 16'd3,     16'hFFF9,  16'hFFFD,  3'd3, 16'hFFFD,  0, 0);
    add(K_EQ,  16'd0,     16'hFFF9,  16'hFFFD,  3'd3, 16'hFFF9,  0, 1);
    add(K_ACK, 16'd21,    16'd21,    16'hFFFD,  3'd3, 16'd21,    0, 0);
    // Digit-count limit
    add(K_RST, 16'd0,     16'd0,     16'd0,     3'd0, 16'd0,     0, 0);
    add(K_DIG, 16'd3,     16'd3,     16'd0,     3'd0, 16'd3,     0, 0);
    add(K_DIG, 16'd2,     16'd32,    16'd0,     3'd0, 16'd32,    0, 0);
    add(K_DIG, 16'd7,     16'd327,   16'd0,     3'd0, 16'd327,   0, 0);
    add(K_DIG, 16'd6,     16'd3276,  16'd0,     3'd0, 16'd3276,  0, 0);
    add(K_DIG, 16'd7,     16'd32767, 16'd0,     3'd0, 16'd32767, 0, 0);
    add(K_DIG, 16'd8,     16'd32767, 16'd0,     3'd0, 16'd32767, 1, 0);
    add(K_DIG, 16'd9,     16'd32767, 16'd0,     3'd0, 16'd32767, 1, 0);
    add(K_OP,  16'd1,     16'd32767, 16'd0,     3'd1, 16'd32767, 1, 0);
    add(K_DIG, 16'd1,     16'd32767, 16'd1,     3'd1, 16'd1,     0, 0);
    // Magnitude limit and ignored keys
    add(K_RST, 16'd0,     16'd0,     16'd0,     3'd0, 16'd0,     0, 0);
    add(K_DIG, 16'd3,     16'd3,     16'd0,     3'd0, 16'd3,     0, 0);
    add(K_DIG, 16'd2,     16'd32,    16'd0,     3'd0, 16'd32,    0, 0);
    add(K_DIG, 16'd7,     16'd327,   16'd0,     3'd0, 16'd327,   0, 0);
    add(K_DIG, 16'd6,     16'd3276,  16'd0,     3'd0, 16'd3276,  0, 0);
    add(K_DIG, 16'd8,     16'd3276,  16'd0,     3'd0, 16'd3276,  1, 0);
    add(K_DIG, 16'd7,     16'd32767, 16'd0,     3'd0, 16'd32767, 1, 0);
    add(K_DIG, 16'd11,    16'd32767, 16'd0,     3'd0, 16'd32767, 1, 0);
    add(K_EQ,  16'd0,     16'd32767, 16'd0,     3'd0, 16'd32767, 1, 0);
    add(K_OP,  16'd5,     16'd32767, 16'd0,     3'd0, 16'd32767, 1, 0);
    add(K_OP,  16'd1,     16'd32767, 16'd0,     3'd1, 16'd32767, 1, 0);
    add(K_EQ,  16'd0,     16'd32767, 16'd0,     3'd1, 16'd32767, 1, 0);
    add(K_OP,  16'd3,     16'd32767, 16'd0,     3'd3, 16'd32767, 1, 0);
    add(K_DIG, 16'd5,     16'd32767, 16'd5,     3'd3, 16'd5,     0, 0);
    add(K_OP,  16'd1,     16'd32767, 16'd5,     3'd3, 16'd5,     0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (v.kind == K_ACK) begin
        calc_result = v.val; calc_ack = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        calc_ack = 1'b0;
        e = sb.pop_front();
        cmp(i, e);
      end else if (v.kind == K_RST) begin
        RST = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        RST = 1'b0;
        e = sb.pop_front();
        cmp(i, e);
      end else begin
        drive_key(v.kind, v.val);
        sb.push_back(v);
        n = 0;
        do begin @(negedge clk); n++; end while (!KeyRd && n < 20);
        chk($sformatf("keyrd_latency[%0d]", i), n, 1);
        e = sb.pop_front();
        cmp(i, e);
        release_key();
        @(negedge clk);
        chk($sformatf("keyrd_pulse[%0d]", i), KeyRd, 1'b0);
      end
    end

    // Key held during CALC stalls, then is acknowledged exactly once in RESULT.
    do_reset();
    press(K_DIG, 16'd1); press(K_OP, 16'd1); press(K_DIG, 16'd2); press(K_EQ, 16'd0);
    chk("stall_req", calc_req, 1'b1);
    drive_key(K_DIG, 16'd9);
    pulses = 0;
    repeat (5) begin @(negedge clk); if (KeyRd) pulses++; end
    chk("stall_no_keyrd", pulses, 0);
    chk("stall_req_held", calc_req, 1'b1);
    chk("stall_a_frozen", operand_a, 16'd1);
    chk("stall_b_frozen", operand_b, 16'd2);
    calc_result = 16'd3; calc_ack = 1'b1;
    @(negedge clk);
    calc_ack = 1'b0;
    chk("stall_ack_a", operand_a, 16'd3);
    chk("stall_ack_req", calc_req, 1'b0);
    chk("stall_ack_keyrd", KeyRd, 1'b0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (KeyRd) begin pulses++; release_key(); end
    end
    release_key();
    chk("stall_ack_once", pulses, 1);
    chk("stall_new_a", operand_a, 16'd9);

    // Reset while in CALC; a later stray ack has no effect.
    do_reset();
    press(K_DIG, 16'd4); press(K_OP, 16'd2); press(K_DIG, 16'd6); press(K_EQ, 16'd0);
    chk("rcalc_req_before", calc_req, 1'b1);
    do_reset();
    chk("rcalc_req", calc_req, 1'b0);
    chk("rcalc_a", operand_a, 16'd0);
    chk("rcalc_b", operand_b, 16'd0);
    chk("rcalc_op", op_code, 3'd0);
    chk("rcalc_disp", display_value, 16'd0);
    chk("rcalc_err", entry_err, 1'b0);
    chk("rcalc_keyrd", KeyRd, 1'b0);
    calc_result = 16'h1234; calc_ack = 1'b1;
    @(negedge clk);
    calc_ack = 1'b0;
    chk("stray_ack_a", operand_a, 16'd0);
    chk("stray_ack_req", calc_req, 1'b0);
    press(K_DIG, 16'd5);
    chk("rcalc_enter_a", operand_a, 16'd5);
    chk("rcalc_enter_disp", display_value, 16'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
